gather_fifo: RTL and testbench

Multi-port in-order buffer that accepts a sparse set of up to IN write lanes per cycle, compacts them in lane order into a circular store, and presents up to OUT oldest entries per cycle for in-order retirement. It is the sequencing stage that sits behind the gather compaction network and holds its packed output until downstream consumers drain it at their own rate. Typical uses are dispatch queues, write-combining buffers and multi-issue retire paths, where producers and consumers have different per-cycle widths.

---
 rtl/gather_fifo.sv | 116 +++++++++++
 tb/tb_gather_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gather_fifo.sv
// rtl/gather_fifo.sv - multi-port in-order buffer with lane compaction on enqueue
//
// Purpose: accepts a sparse mask of up to IN enqueue lanes per cycle, packs the
// set lanes in ascending lane order into a circular store, and presents the OUT
// oldest entries for in-order retirement.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (head = tail = count = 0)
//   flush      synchronous clear of all entries, beats enqueue and dequeue
//   we         sparse enqueue mask, lane k valid when we[k] = 1
//   in         enqueue data, one DATA-wide word per lane
//   in_ready   buffer can absorb any we pattern this cycle
//   out        oldest entries, lane 0 oldest, zero when not valid
//   out_valid  thermometer code, out_valid[k] = (count > k)
//   re         dequeue request per output lane
//   count      number of occupied entries
module gather_fifo #(
   parameter int DATA  = 32,
   parameter int IN    = 4,
   parameter int OUT   = 2,
   parameter int DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic [IN-1:0]                  we,
   input  logic [IN-1:0][DATA-1:0]        in,
   output logic                           in_ready,
   output logic [OUT-1:0][DATA-1:0]       out,
   output logic [OUT-1:0]                 out_valid,
   input  logic [OUT-1:0]                 re,
   output logic [$clog2(DEPTH):0]         count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA-1:0] mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count_q;

   logic [PW-1:0]   wr_idx [IN];
   logic [CW-1:0]   nenq;
   logic [CW-1:0]   ndeq;
   logic            enq_fire;
   logic            run;

   assign count    = count_q;
   // Readiness looks only at registered count, so a same-cycle dequeue can
   // never open room for a same-cycle enqueue.
   assign in_ready = (count_q <= CW'(DEPTH - IN));
   assign enq_fire = in_ready && (|we);

   // Each set lane lands at tail plus the number of set lanes below it.
   always_comb begin
      nenq = '0;
      for (int k = 0; k < IN; k++) begin
         wr_idx[k] = tail + nenq[PW-1:0];
         if (we[k]) begin
            nenq = nenq + CW'(1);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < OUT; k++) begin
         out_valid[k] = (count_q > CW'(k));
         out[k]       = out_valid[k] ? mem[head + PW'(k)] : '0;
      end
   end

   // Only the leading run of granted lanes retires; a hole stops the run.
   always_comb begin
      ndeq = '0;
      run  = 1'b1;
      for (int k = 0; k < OUT; k++) begin
         if (run && re[k] && out_valid[k]) begin
            ndeq = ndeq + CW'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (enq_fire) begin
            tail <= tail + nenq[PW-1:0];
         end
         head    <= head + ndeq[PW-1:0];
         count_q <= count_q + (enq_fire ? nenq : '0) - ndeq;
      end
   end

   // Storage carries no reset; stale words are masked by out_valid.
   always_ff @(posedge clk) begin
      if (enq_fire && !flush) begin
         for (int k = 0; k < IN; k++) begin
            if (we[k]) begin
               mem[wr_idx[k]] <= in[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_gather_fifo.sv
// tb/tb_gather_fifo.sv - self-checking bench for gather_fifo against a queue model
module tb_gather_fifo;

   logic             clk;
   logic             reset;
   logic             flush;
   logic [3:0]       we;
   logic [3:0][31:0] din;
   logic             in_ready;
   logic [1:0][31:0] dout;
   logic [1:0]       out_valid;
   logic [1:0]       re;
   logic [4:0]       count;

   int total = 0;
   int bad   = 0;

   logic [31:0] q[$];
   int          m_tail = 0;

   gather_fifo #(.DATA(32), .IN(4), .OUT(2), .DEPTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .we        (we),
      .in        (din),
      .in_ready  (in_ready),
      .out       (dout),
      .out_valid (out_valid),
      .re        (re),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = q.size();
      chk({tag, "_count"}, 32'(count), 32'(sz));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'((16 - sz) >= 4));
      chk({tag, "_out_valid"}, 32'(out_valid), {30'd0, sz > 1, sz > 0});
      chk({tag, "_out0"}, dout[0], (sz > 0) ? q[0] : 32'd0);
      chk({tag, "_out1"}, dout[1], (sz > 1) ? q[1] : 32'd0);
   endtask

   // Apply one cycle of stimulus, advance the model by the buffer's rules,
   // then compare after the edge.
   task automatic step(input logic [3:0] w, input logic [1:0] r, input logic f, input string tag);
      int  sz;
      int  nd;
      bit  rdy;
      we    = w;
      re    = r;
      flush = f;
      sz  = q.size();
      rdy = (16 - sz) >= 4;
      if (f) begin
         q.delete();
         m_tail = 0;
      end else begin
         nd = 0;
         for (int k = 0; k < 2; k++) begin
            if (r[k] && k < sz && nd == k) nd++;
         end
         repeat (nd) void'(q.pop_front());
         if (rdy) begin
            for (int k = 0; k < 4; k++) begin
               if (w[k]) begin
                  q.push_back(din[k]);
                  m_tail = (m_tail + 1) % 16;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      we    = '0;
      re    = '0;
      flush = 1'b0;
      check_all(tag);
   endtask

   task automatic rand_din();
      for (int k = 0; k < 4; k++) din[k] = $urandom;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         step(4'h0, 2'b11, 1'b0, "drain");
         guard++;
      end
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      we    = '0;
      re    = '0;
      din   = '0;
      #2;
      check_all("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // sparse enqueue compacts lanes 1 and 3
      din[1] = 32'hA;
      din[3] = 32'hB;
      step(4'b1010, 2'b00, 1'b0, "sparse");
      chk("sparse_out0_const", dout[0], 32'hA);
      chk("sparse_out1_const", dout[1], 32'hB);
      chk("sparse_count_const", 32'(count), 32'd2);

      // simultaneous dequeue of two and enqueue of one
      din[0] = 32'hC;
      step(4'b0001, 2'b11, 1'b0, "enq_deq");
      chk("enq_deq_out0_const", dout[0], 32'hC);

      // fill to 13, then a full-width request must be refused
      rand_din(); step(4'hF, 2'b00, 1'b0, "fill1");
      rand_din(); step(4'hF, 2'b00, 1'b0, "fill2");
      rand_din(); step(4'hF, 2'b00, 1'b0, "fill3");
      chk("fill13_in_ready", 32'(in_ready), 32'd0);
      rand_din(); step(4'hF, 2'b00, 1'b0, "refused");
      chk("refused_count_const", 32'(count), 32'd13);
      step(4'h0, 2'b01, 1'b0, "deq_one");
      chk("deq_one_ready_const", 32'(in_ready), 32'd1);

      // bring count to 5, then a gapped request must retire nothing
      step(4'h0, 2'b11, 1'b0, "to5a");
      step(4'h0, 2'b11, 1'b0, "to5b");
      step(4'h0, 2'b11, 1'b0, "to5c");
      step(4'h0, 2'b01, 1'b0, "to5d");
      step(4'h0, 2'b10, 1'b0, "gap");
      chk("gap_count_const", 32'(count), 32'd5);

      // wrap-around: move tail to 14 then write four entries across the end
      drain();
      for (int i = 0; i < 20 && m_tail != 14; i++) begin
         din[0] = $urandom;
         step(4'b0001, 2'b01, 1'b0, "walk");
      end
      step(4'h0, 2'b01, 1'b0, "walk_drain");
      chk("walk_tail", 32'(m_tail), 32'd14);
      din[0] = 32'h1111_0000;
      din[1] = 32'h2222_0001;
      din[2] = 32'h3333_0002;
      din[3] = 32'h4444_0003;
      step(4'hF, 2'b00, 1'b0, "wrap");
      chk("wrap_mem14", dut.mem[14], 32'h1111_0000);
      chk("wrap_mem15", dut.mem[15], 32'h2222_0001);
      chk("wrap_mem0",  dut.mem[0],  32'h3333_0002);
      chk("wrap_mem1",  dut.mem[1],  32'h4444_0003);
      step(4'h0, 2'b11, 1'b0, "wrap_deq1");
      chk("wrap_deq1_out0", dout[0], 32'h3333_0002);
      step(4'h0, 2'b11, 1'b0, "wrap_deq2");

      // randomized traffic with occasional flush
      for (int i = 0; i < 300; i++) begin
         rand_din();
         step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 31) == 0), "rand");
      end

      // flush beats enqueue and dequeue at count 6
      drain();
      rand_din(); step(4'hF, 2'b00, 1'b0, "pre_flush1");
      rand_din(); step(4'b0011, 2'b00, 1'b0, "pre_flush2");
      chk("pre_flush_count", 32'(count), 32'd6);
      rand_din(); step(4'hF, 2'b11, 1'b1, "flush");
      chk("flush_count_const", 32'(count), 32'd0);

      // asynchronous reset between edges at count 6
      rand_din(); step(4'hF, 2'b00, 1'b0, "pre_rst1");
      rand_din(); step(4'b0011, 2'b00, 1'b0, "pre_rst2");
      #2;
      reset = 1'b1;
      #1;
      q.delete();
      m_tail = 0;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      check_all("async_rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      rand_din(); step(4'b0101, 2'b00, 1'b0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
